// File: rtl/ucsbece154b_perf_pkg.sv
// Shared constants for the dual-issue performance monitor: opcodes, FSM states, read map.
package ucsbece154b_perf_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [2:0] RA_CYCLE       = 3'd0;
    localparam logic [2:0] RA_INSTR       = 3'd1;
    localparam logic [2:0] RA_BRANCH      = 3'd2;
    localparam logic [2:0] RA_BRANCH_MISS = 3'd3;
    localparam logic [2:0] RA_JUMP        = 3'd4;
    localparam logic [2:0] RA_JUMP_MISS   = 3'd5;
    localparam logic [2:0] RA_STATUS      = 3'd6;

    // Number of slots (0..2) raising an event this cycle.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter adding 0..2 per enabled cycle; clamps at all-ones.
module ucsbece154b_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, count} + {{(CNT_W-1){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// In-core performance monitor: event counters, halt/timeout FSM and a registered read port.
module ucsbece154b_perf_monitor
    import ucsbece154b_perf_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter int          MAX_CYCLES = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [31:0]      PCF_i,
    input  logic [31:0]      PCF2_i,
    input  logic [31:0]      InstrF_i,
    input  logic [31:0]      InstrF2_i,
    input  logic [31:0]      PCE_i,
    input  logic [31:0]      PCE2_i,
    input  logic [6:0]       opE_i,
    input  logic [6:0]       opE2_i,
    input  logic             MispredE_i,
    input  logic             MispredE2_i,
    input  logic             TakenE_i,
    input  logic             TakenE2_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_addr_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             done_o
);

    localparam logic [63:0] TIMEOUT_AT = 64'(MAX_CYCLES - 1);

    state_t            state, state_nx;
    logic [31:0]       prev1, prev2;
    logic              halt, timeout_hit, run;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt, branch_cnt, branch_miss_cnt, jump_cnt, jump_miss_cnt;
    logic [CNT_W-1:0]  rd_mux;

    logic v1, v2, br1, br2, jp1, jp2;

    assign v1  = (PCE_i  != 32'd0);
    assign v2  = (PCE2_i != 32'd0);
    assign br1 = v1 && (opE_i  == OP_BRANCH);
    assign br2 = v2 && (opE2_i == OP_BRANCH);
    assign jp1 = v1 && ((opE_i  == OP_JAL) || (opE_i  == OP_JALR));
    assign jp2 = v2 && ((opE2_i == OP_JAL) || (opE2_i == OP_JALR));

    assign run  = (state == ST_RUN);
    assign halt = (PCF_i == prev1) && (InstrF_i == NOP_INSTR) &&
                  (PCF2_i == prev2) && (InstrF2_i == NOP_INSTR);
    // Compare in 64 bits so a narrow counter can never alias the timeout count.
    assign timeout_hit = (64'(cycle_cnt) == TIMEOUT_AT);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev1 <= 32'd0;
            prev2 <= 32'd0;
        end else begin
            prev1 <= PCF_i;
            prev2 <= PCF2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) state <= ST_RUN;
        else                  state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done_o   = 1'b1;
        case (state)
            ST_RUN: begin
                done_o = 1'b0;
                if (halt)             state_nx = ST_HALTED;
                else if (timeout_hit) state_nx = ST_TIMEOUT;
            end
            ST_HALTED:  state_nx = ST_HALTED;
            ST_TIMEOUT: state_nx = ST_TIMEOUT;
            default:    state_nx = ST_RUN;
        endcase
    end

    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run), .inc(2'd1), .count(cycle_cnt));
    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_instr (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run), .inc(count2(v1, v2)), .count(instr_cnt));
    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_branch (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run), .inc(count2(br1, br2)), .count(branch_cnt));
    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_branch_miss (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run),
        .inc(count2(br1 && MispredE_i, br2 && MispredE2_i)), .count(branch_miss_cnt));
    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_jump (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run), .inc(count2(jp1, jp2)), .count(jump_cnt));
    ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_jump_miss (
        .clk(clk), .reset(reset), .clr(clear_i), .en(run),
        .inc(count2(jp1 && !TakenE_i, jp2 && !TakenE2_i)), .count(jump_miss_cnt));

    always_comb begin
        rd_mux = '0;
        case (rd_addr_i)
            RA_CYCLE:       rd_mux = cycle_cnt;
            RA_INSTR:       rd_mux = instr_cnt;
            RA_BRANCH:      rd_mux = branch_cnt;
            RA_BRANCH_MISS: rd_mux = branch_miss_cnt;
            RA_JUMP:        rd_mux = jump_cnt;
            RA_JUMP_MISS:   rd_mux = jump_miss_cnt;
            RA_STATUS:      rd_mux = CNT_W'(state);
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Scoreboard bench for the perf monitor: a 32-bit and a 4-bit instance share stimulus.
module tb_ucsbece154b_perf_monitor;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] NOT_NOP = 32'h00000033;
    localparam logic [6:0]  OP_ALU  = 7'b0110011;
    localparam logic [6:0]  OP_LD   = 7'b0000011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JL   = 7'b1101111;
    localparam logic [6:0]  OP_JLR  = 7'b1100111;
    localparam int          MAXC    = 500;

    logic        clk = 1'b0;
    logic        reset, clear_i;
    logic [31:0] PCF_i, PCF2_i, InstrF_i, InstrF2_i, PCE_i, PCE2_i;
    logic [6:0]  opE_i, opE2_i;
    logic        MispredE_i, MispredE2_i, TakenE_i, TakenE2_i;
    logic        rd_req_i;
    logic [2:0]  rd_addr_i;
    logic        rd_valid_a, rd_valid_b, done_a, done_b;
    logic [31:0] rd_data_a;
    logic [3:0]  rd_data_b;

    always #5 clk = ~clk;

    ucsbece154b_perf_monitor #(.CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .PCF_i(PCF_i), .PCF2_i(PCF2_i), .InstrF_i(InstrF_i), .InstrF2_i(InstrF2_i),
        .PCE_i(PCE_i), .PCE2_i(PCE2_i), .opE_i(opE_i), .opE2_i(opE2_i),
        .MispredE_i(MispredE_i), .MispredE2_i(MispredE2_i),
        .TakenE_i(TakenE_i), .TakenE2_i(TakenE2_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .done_o(done_a));

    ucsbece154b_perf_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .PCF_i(PCF_i), .PCF2_i(PCF2_i), .InstrF_i(InstrF_i), .InstrF2_i(InstrF2_i),
        .PCE_i(PCE_i), .PCE2_i(PCE2_i), .opE_i(opE_i), .opE2_i(opE2_i),
        .MispredE_i(MispredE_i), .MispredE2_i(MispredE2_i),
        .TakenE_i(TakenE_i), .TakenE2_i(TakenE2_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b), .done_o(done_b));

    // Reference model: counters 0..5 in read-map order; state 0=RUN 1=HALTED 2=TIMEOUT.
    longint      m_cnt[2][6];
    longint      m_max[2];
    int          m_state[2];
    bit          m_vexp[2];
    longint      m_last[2];
    logic [31:0] m_prev1, m_prev2;
    longint      q0[$];
    longint      q1[$];

    int checks = 0;
    int errors = 0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint mval(input int i, input logic [2:0] a);
        if (a <= 3'd5) return m_cnt[i][a];
        if (a == 3'd6) return longint'(m_state[i]);
        return 0;
    endfunction

    function automatic longint sat_add(input longint v, input int n, input longint mx);
        return (v + n > mx) ? mx : v + n;
    endfunction

    task automatic model_step();
        bit halt;
        int n_ins, n_br, n_brm, n_jp, n_jpm;
        halt = (PCF_i == m_prev1) && (InstrF_i == NOP) && (PCF2_i == m_prev2) && (InstrF2_i == NOP);
        n_ins = 0; n_br = 0; n_brm = 0; n_jp = 0; n_jpm = 0;
        if (PCE_i != 0) begin
            n_ins++;
            if (opE_i == OP_BR) begin n_br++; if (MispredE_i) n_brm++; end
            if (opE_i == OP_JL || opE_i == OP_JLR) begin n_jp++; if (!TakenE_i) n_jpm++; end
        end
        if (PCE2_i != 0) begin
            n_ins++;
            if (opE2_i == OP_BR) begin n_br++; if (MispredE2_i) n_brm++; end
            if (opE2_i == OP_JL || opE2_i == OP_JLR) begin n_jp++; if (!TakenE2_i) n_jpm++; end
        end
        for (int i = 0; i < 2; i++) begin
            m_vexp[i] = rd_req_i && !reset;
            if (m_vexp[i]) begin
                if (i == 0) q0.push_back(mval(0, rd_addr_i));
                else        q1.push_back(mval(1, rd_addr_i));
            end
            if (reset) m_last[i] = 0;
            if (reset || clear_i) begin
                for (int k = 0; k < 6; k++) m_cnt[i][k] = 0;
                m_state[i] = 0;
            end else if (m_state[i] == 0) begin
                if (halt)                       m_state[i] = 1;
                else if (m_cnt[i][0] == MAXC-1) m_state[i] = 2;
                m_cnt[i][0] = sat_add(m_cnt[i][0], 1, m_max[i]);
                m_cnt[i][1] = sat_add(m_cnt[i][1], n_ins, m_max[i]);
                m_cnt[i][2] = sat_add(m_cnt[i][2], n_br, m_max[i]);
                m_cnt[i][3] = sat_add(m_cnt[i][3], n_brm, m_max[i]);
                m_cnt[i][4] = sat_add(m_cnt[i][4], n_jp, m_max[i]);
                m_cnt[i][5] = sat_add(m_cnt[i][5], n_jpm, m_max[i]);
            end
        end
        m_prev1 = reset ? 32'd0 : PCF_i;
        m_prev2 = reset ? 32'd0 : PCF2_i;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 0; clear_i = 0; rd_req_i = 0; rd_addr_i = 0;
        PCE_i = 0; PCE2_i = 0; opE_i = OP_ALU; opE2_i = OP_ALU;
        MispredE_i = 0; MispredE2_i = 0; TakenE_i = 0; TakenE2_i = 0;
        PCF_i = pc_ctr; PCF2_i = pc_ctr + 4; pc_ctr += 8;
        InstrF_i = NOT_NOP; InstrF2_i = NOT_NOP;
    endtask

    task automatic do_read(input logic [2:0] a);
        set_idle(); rd_req_i = 1; rd_addr_i = a; tick();
    endtask

    task automatic do_clear();
        set_idle(); clear_i = 1; tick();
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents read data.
    initial begin
        longint e;
        forever begin
            @(posedge clk); #1;
            chk("valid_a", longint'(rd_valid_a), longint'(m_vexp[0]));
            chk("valid_b", longint'(rd_valid_b), longint'(m_vexp[1]));
            chk("done_a", longint'(done_a), longint'(m_state[0] != 0));
            chk("done_b", longint'(done_b), longint'(m_state[1] != 0));
            if (rd_valid_a) begin
                if (q0.size() == 0) chk("data_a_unexpected", 1, 0);
                else begin e = q0.pop_front(); chk("data_a", longint'(rd_data_a), e); m_last[0] = e; end
            end else chk("hold_a", longint'(rd_data_a), m_last[0]);
            if (rd_valid_b) begin
                if (q1.size() == 0) chk("data_b_unexpected", 1, 0);
                else begin e = q1.pop_front(); chk("data_b", longint'(rd_data_b), e); m_last[1] = e; end
            end else chk("hold_b", longint'(rd_data_b), m_last[1]);
        end
    end

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 15;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 6; k++) m_cnt[i][k] = 0;
            m_state[i] = 0; m_vexp[i] = 0; m_last[i] = 0;
        end
        m_prev1 = 0; m_prev2 = 0;

        set_idle(); reset = 1; tick();
        set_idle(); reset = 1; tick();

        for (int c = 0; c < 10; c++) begin
            set_idle(); PCE_i = 32'h40; PCE2_i = 32'h40; tick();
        end
        do_read(3'd0);
        do_read(3'd1);

        do_clear();
        for (int c = 0; c < 3; c++) begin
            set_idle(); PCE_i = 32'h80; PCE2_i = 32'h84;
            opE_i = OP_BR; opE2_i = OP_BR; MispredE_i = 1; MispredE2_i = 0; tick();
        end
        do_read(3'd2);
        do_read(3'd3);

        do_clear();
        set_idle(); PCE_i = 32'h90; PCE2_i = 32'h94;
        opE_i = OP_JL; opE2_i = OP_JLR; TakenE_i = 0; TakenE2_i = 1; tick();
        set_idle(); PCE_i = 0; opE_i = OP_JL; tick();
        do_read(3'd4);
        do_read(3'd5);

        for (int c = 0; c < 2; c++) begin
            set_idle(); PCF_i = 32'h100; PCF2_i = 32'h104; InstrF_i = NOP; InstrF2_i = NOP;
            PCE_i = 32'h40; tick();
        end
        for (int c = 0; c < 3; c++) begin set_idle(); PCE_i = 32'h40; tick(); end
        do_read(3'd6);
        do_read(3'd0);
        do_read(3'd0);
        do_clear();
        for (int a = 0; a < 8; a++) do_read(3'(a));

        for (int c = 0; c < 400; c++) begin
            logic [31:0] hold1, hold2;
            hold1 = PCF_i; hold2 = PCF2_i;
            set_idle();
            if ($urandom_range(0, 14) == 0) begin
                PCF_i = hold1; PCF2_i = hold2; InstrF_i = NOP; InstrF2_i = NOP;
            end
            PCE_i  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            PCE2_i = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 4))
                0: opE_i = OP_BR; 1: opE_i = OP_JL; 2: opE_i = OP_JLR; 3: opE_i = OP_LD; default: opE_i = OP_ALU;
            endcase
            case ($urandom_range(0, 4))
                0: opE2_i = OP_BR; 1: opE2_i = OP_JL; 2: opE2_i = OP_JLR; 3: opE2_i = OP_LD; default: opE2_i = OP_ALU;
            endcase
            MispredE_i = 1'($urandom); MispredE2_i = 1'($urandom);
            TakenE_i = 1'($urandom); TakenE2_i = 1'($urandom);
            rd_req_i = ($urandom_range(0, 2) == 0);
            rd_addr_i = 3'($urandom);
            clear_i = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        do_clear();
        for (int c = 0; c < 505; c++) begin set_idle(); PCE_i = 32'h40; tick(); end
        do_read(3'd6);
        do_read(3'd0);

        do_clear();
        for (int c = 0; c < 498; c++) tick_idle_helper();
        for (int c = 0; c < 2; c++) begin
            set_idle(); PCF_i = 32'h200; PCF2_i = 32'h204; InstrF_i = NOP; InstrF2_i = NOP; tick();
        end
        do_read(3'd6);
        do_read(3'd0);

        set_idle(); rd_req_i = 1; rd_addr_i = 3'd0; reset = 1; tick();
        set_idle(); tick();
        set_idle(); tick();

        chk("scoreboard_empty_a", longint'(q0.size()), 0);
        chk("scoreboard_empty_b", longint'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic tick_idle_helper();
        set_idle(); tick();
    endtask

endmodule
